// File: rtl/ysyx_25060170_lsu_pkg.sv
// ysyx_25060170 LSU shared definitions.
// FSM state encoding and access size codes.
package ysyx_25060170_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/ysyx_25060170_lsu_align.sv
// ysyx_25060170 LSU lane logic: store strobes/replication, load shift/extend.
// Misalignment detection only when YSYX_25060170_LSU_MISALIGN_EN is defined.
module ysyx_25060170_lsu_align
    import ysyx_25060170_lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_chk_addr_lo,
    input  logic [1:0]  i_chk_size,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [4:0]  w_shamt;
    logic [31:0] w_sh;

    // Half accesses select their lane pair with addr[1] only.
    always_comb begin
        w_shamt = 5'd0;
        o_wmask = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            SZ_B: begin
                w_shamt = {i_addr_lo, 3'b000};
                o_wmask = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                w_shamt = {i_addr_lo[1], 4'b0000};
                o_wmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_sh = i_rdata >> w_shamt;

    always_comb begin
        o_rdata = w_sh;
        case (i_size)
            SZ_B: o_rdata = {{24{i_sign & w_sh[7]}}, w_sh[7:0]};
            SZ_H: o_rdata = {{16{i_sign & w_sh[15]}}, w_sh[15:0]};
            default: ;
        endcase
    end

`ifdef YSYX_25060170_LSU_MISALIGN_EN
    always_comb begin
        o_misalign = 1'b0;
        case (i_chk_size)
            SZ_B:    o_misalign = 1'b0;
            SZ_H:    o_misalign = i_chk_addr_lo[0];
            default: o_misalign = |i_chk_addr_lo;
        endcase
    end
`else
    logic w_unused;
    assign w_unused   = ^{i_chk_addr_lo, i_chk_size};
    assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/ysyx_25060170_lsu.sv
// ysyx_25060170 multi-cycle load/store unit between EXU and WBU.
// Optional misalignment trap: YSYX_25060170_LSU_MISALIGN_EN.
module ysyx_25060170_lsu
    import ysyx_25060170_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [4:0]        out_rd,
    output logic              out_is_load,
    output logic              out_err
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wen;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [3:0]        w_wmask;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ldata;
    logic              w_misalign;
    logic              w_req;
    logic              w_done;

    ysyx_25060170_lsu_align u_align (
        .i_addr_lo     (r_addr[1:0]),
        .i_size        (r_size),
        .i_sign        (r_sign),
        .i_wdata       (r_wdata),
        .i_rdata       (mem_rdata),
        .i_chk_addr_lo (req_addr[1:0]),
        .i_chk_size    (req_size),
        .o_wmask       (w_wmask),
        .o_wdata       (w_wdata),
        .o_rdata       (w_ldata),
        .o_misalign    (w_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid)     w_next = w_misalign ? S_DONE : S_REQ;
            S_REQ:  if (mem_req_ready) w_next = S_WAIT;
            S_WAIT: if (mem_rsp_valid) w_next = S_DONE;
            S_DONE: if (out_ready)     w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_size  <= 2'd0;
            r_sign  <= 1'b0;
            r_rd    <= 5'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_wen   <= req_wen;
                    r_size  <= req_size;
                    r_sign  <= req_sign;
                    r_rd    <= req_rd;
                    r_rdata <= '0;
                    r_err   <= w_misalign;
                end
                // Stores and faulted loads report zero data.
                S_WAIT: if (mem_rsp_valid) begin
                    r_err   <= mem_rsp_err;
                    r_rdata <= (mem_rsp_err || r_wen) ? '0 : w_ldata;
                end
                default: ;
            endcase
        end
    end

    assign w_req  = (r_state == S_REQ);
    assign w_done = (r_state == S_DONE);

    assign req_ready     = (r_state == S_IDLE);
    assign mem_req_valid = w_req;
    assign mem_addr      = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wen       = w_req & r_wen;
    assign mem_wdata     = (w_req && r_wen) ? w_wdata : '0;
    assign mem_wmask     = (w_req && r_wen) ? w_wmask : 4'b0000;

    assign out_valid   = w_done;
    assign out_rdata   = w_done ? r_rdata : '0;
    assign out_rd      = w_done ? r_rd : 5'd0;
    assign out_is_load = w_done & ~r_wen;
    assign out_err     = w_done & r_err;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Directed self-checking bench for ysyx_25060170_lsu.
// Covers loads, stores, backpressure, errors, misalignment and mid-op reset.
module tb_ysyx_25060170_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_sign = 1'b0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rsp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_is_load;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_25060170_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wen       (req_wen),
        .req_size      (req_size),
        .req_sign      (req_sign),
        .req_rd        (req_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .mem_rsp_err   (mem_rsp_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_rd        (out_rd),
        .out_is_load   (out_is_load),
        .out_err       (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while idle; returns at the next falling edge.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [1:0] s,
                          input logic sg, input logic [4:0] rd);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wen   = w;
        req_size  = s;
        req_sign  = sg;
        req_rd    = rd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic bus(input logic [31:0] rdata, input logic err);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        mem_rsp_err   = err;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_out", 32'(req_ready), 32'd1);
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_is_load", 32'(out_is_load), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Word load
        do_req(32'h8000_0104, 32'd0, 1'b0, 2'd2, 1'b0, 5'd5);
        chk("wl_mem_valid", 32'(mem_req_valid), 32'd1);
        chk("wl_mem_addr", mem_addr, 32'h8000_0104);
        chk("wl_mem_wen", 32'(mem_wen), 32'd0);
        chk("wl_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("wl_req_ready", 32'(req_ready), 32'd0);
        bus(32'hDEAD_BEEF, 1'b0);
        chk("wl_out_valid", 32'(out_valid), 32'd1);
        chk("wl_out_rdata", out_rdata, 32'hDEAD_BEEF);
        chk("wl_out_rd", 32'(out_rd), 32'd5);
        chk("wl_is_load", 32'(out_is_load), 32'd1);
        chk("wl_err", 32'(out_err), 32'd0);
        consume();

        // Signed and unsigned byte load from lane 3
        do_req(32'h8000_0103, 32'd0, 1'b0, 2'd0, 1'b1, 5'd7);
        chk("lbs_mem_addr", mem_addr, 32'h8000_0100);
        bus(32'h8012_3456, 1'b0);
        chk("lbs_out_rdata", out_rdata, 32'hFFFF_FF80);
        consume();
        do_req(32'h8000_0103, 32'd0, 1'b0, 2'd0, 1'b0, 5'd7);
        bus(32'h8012_3456, 1'b0);
        chk("lbu_out_rdata", out_rdata, 32'h0000_0080);
        consume();

        // Signed half load from upper half
        do_req(32'h8000_0002, 32'd0, 1'b0, 2'd1, 1'b1, 5'd9);
        bus(32'h8001_0000, 1'b0);
        chk("lhs_out_rdata", out_rdata, 32'hFFFF_8001);
        consume();

        // Size 3 behaves as word
        do_req(32'h8000_0008, 32'd0, 1'b0, 2'd3, 1'b0, 5'd2);
        bus(32'h1122_3344, 1'b0);
        chk("lsz3_out_rdata", out_rdata, 32'h1122_3344);
        consume();

        // Half store
        do_req(32'h8000_0002, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 5'd3);
        chk("sh_mem_wen", 32'(mem_wen), 32'd1);
        chk("sh_mem_addr", mem_addr, 32'h8000_0000);
        chk("sh_mem_wmask", 32'(mem_wmask), 32'hC);
        chk("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
        bus(32'hFFFF_FFFF, 1'b0);
        chk("sh_out_valid", 32'(out_valid), 32'd1);
        chk("sh_is_load", 32'(out_is_load), 32'd0);
        chk("sh_out_rdata", out_rdata, 32'd0);
        consume();

        // Byte store to lane 1
        do_req(32'h8000_0011, 32'h0000_0077, 1'b1, 2'd0, 1'b0, 5'd0);
        chk("sb_mem_wmask", 32'(mem_wmask), 32'h2);
        chk("sb_mem_wdata", mem_wdata, 32'h7777_7777);
        bus(32'd0, 1'b0);
        consume();

        // Backpressure on every handshake
        do_req(32'h8000_0010, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b0, 5'd12);
        for (int i = 0; i < 5; i++) begin
            chk("bp_mem_valid", 32'(mem_req_valid), 32'd1);
            chk("bp_mem_wdata", mem_wdata, 32'hCAFE_F00D);
            chk("bp_mem_wmask", 32'(mem_wmask), 32'hF);
            chk("bp_mem_addr", mem_addr, 32'h8000_0010);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wait_mem_valid", 32'(mem_req_valid), 32'd0);
            chk("bp_wait_out_valid", 32'(out_valid), 32'd0);
            chk("bp_wait_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_rd", 32'(out_rd), 32'd12);
            chk("bp_out_rdata", out_rdata, 32'd0);
            chk("bp_req_ready_done", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        consume();

        // Bus error
        do_req(32'h8000_0020, 32'd0, 1'b0, 2'd2, 1'b0, 5'd4);
        bus(32'h0000_0055, 1'b1);
        chk("err_out_err", 32'(out_err), 32'd1);
        chk("err_out_rdata", out_rdata, 32'd0);
        consume();

        // Misaligned word load
        do_req(32'h8000_0001, 32'd0, 1'b0, 2'd2, 1'b0, 5'd6);
`ifdef YSYX_25060170_LSU_MISALIGN_EN
        chk("mis_out_valid", 32'(out_valid), 32'd1);
        chk("mis_out_err", 32'(out_err), 32'd1);
        chk("mis_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("mis_out_rdata", out_rdata, 32'd0);
`else
        chk("mis_mem_valid", 32'(mem_req_valid), 32'd1);
        chk("mis_mem_addr", mem_addr, 32'h8000_0000);
        bus(32'hAABB_CCDD, 1'b0);
        chk("mis_out_rdata", out_rdata, 32'hAABB_CCDD);
        chk("mis_out_err", 32'(out_err), 32'd0);
`endif
        consume();

        // Reset while waiting for the response
        do_req(32'h8000_0030, 32'd0, 1'b0, 2'd2, 1'b0, 5'd8);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        chk("mrst_mem_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rsp_out_valid", 32'(out_valid), 32'd0);
            chk("late_rsp_req_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_lsu.md
# ysyx_25060170_lsu

Multi-cycle load/store unit between the EXU and the WBU of the ysyx_25060170 core. It accepts one memory operation at a time from the execute stage, performs it over a ready/valid data-memory port, and hands the aligned, extended result to write-back. It replaces the combinational memory path so that data memory may have arbitrary latency.

## Interface
- Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Fixed at 32; other values are unsupported.
- Ports:
- `clk` input 1: the only clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: EXU offers an operation.
- `req_ready` output 1: LSU accepts the operation. High only in IDLE.
- `req_addr` input 32: byte address, equal to the EXU result.
- `req_wdata` input 32: store data, equal to rs2.
- `req_wen` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word. 3 is treated as word.
- `req_sign` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_rd` input 5: destination register, passed through to the output.
- `mem_req_valid` output 1: bus request.
- `mem_req_ready` input 1: bus accepts the request.
- `mem_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wen` output 1: bus write enable.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_wmask` output 4: byte strobes.
- `mem_rsp_valid` input 1: bus response. Present for both reads and writes.
- `mem_rdata` input 32: read data.
- `mem_rsp_err` input 1: bus error, qualified by `mem_rsp_valid`.
- `out_valid` output 1: result available to the WBU.
- `out_ready` input 1: WBU consumes the result.
- `out_rdata` output 32: extended load data. 0 for stores and on error.
- `out_rd` output 5: latched `req_rd`.
- `out_is_load` output 1: latched `!req_wen`.
- `out_err` output 1: bus error or misaligned access.

## Operation
- FSM states: IDLE → REQ → WAIT → DONE → IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch addr, wdata, wen, size, sign and rd, then go to REQ.
  - If misalignment checking is enabled and the access is misaligned, go straight to DONE with `out_err`=1.
- REQ:
  - `mem_req_valid`=1, with address, wen, wdata and wmask held stable.
  - On `mem_req_ready`, go to WAIT.
- WAIT: on `mem_rsp_valid`, latch the result and go to DONE.
  - Load: right-shift `mem_rdata` by `addr[1:0]*8`, then extend to 32 bits per size and sign.
  - Error: `out_rdata`=0, `out_err`=1.
- DONE:
  - `out_valid`=1 with all `out_*` outputs stable.
  - On `out_ready`, go to IDLE.
- Store lanes:
  - Byte: `wmask`=`4'b0001<<addr[1:0]`, `wdata`=`{4{d[7:0]}}`.
  - Half: `wmask`=`4'b0011<<addr[1:0]`, `wdata`=`{2{d[15:0]}}`.
  - Word: `wmask`=`4'b1111`, `wdata`=`d`.
- For loads, `mem_wen`=0 and `mem_wmask`=0.

## Timing
- Reset (`rst`=0, asynchronous):
  - State returns to IDLE.
  - `req_ready`=1 (IDLE decode).
  - All other outputs are 0.
  - Latched registers are 0.
- A reset asserted mid-operation abandons the transaction. No response is expected afterwards, and a stale `mem_rsp_valid` arriving in IDLE is ignored.
- Minimum latency: request accepted in cycle N → `mem_req_valid` in N+1 → response in N+2 at the earliest → `out_valid` in N+3.
- A response arriving in the same cycle as the `mem_req_ready` handshake is not allowed. The LSU ignores `mem_rsp_valid` outside WAIT.
- A misaligned request when checking is enabled: `out_valid` in N+1, with no bus activity.
- Back-to-back: `req_ready` is high in the cycle after the `out_valid`&&`out_ready` handshake. There is no overlap between operations.
- Handshake rule: `mem_req_valid` and `out_valid`, once raised, are never dropped before their ready is sampled high. The payload on those interfaces does not change while valid is high.

## Configuration
- Macro: `YSYX_25060170_LSU_MISALIGN_EN`.
- Defined:
  - Half accesses with `addr[0]`≠0 are misaligned.
  - Word accesses with `addr[1:0]`≠0 are misaligned.
  - A misaligned access raises `out_err`=1, sets `out_rdata`=0, and performs no memory access.
- Undefined:
  - No check is performed.
  - Half accesses use `addr[1]` only.
  - Word accesses ignore `addr[1:0]`.
  - Lanes wrap within the word: the mask is truncated to 4 bits, and the shift uses `addr[1:0]`.

## Structure
- Package `ysyx_25060170_lsu_pkg` holds:
  - the FSM state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3);
  - the size codes (SZ_B, SZ_H, SZ_W).
- Sub-module `ysyx_25060170_lsu_align` is purely combinational:
  - computes store wmask and wdata replication;
  - computes load shift and extension;
  - computes the misaligned flag.
- The FSM and registers stay in the top LSU module.

## Test plan
- Word load: addr `0x8000_0104`, `mem_rdata`=`0xDEADBEEF`, `mem_req_ready` and rsp each after 1 cycle → `mem_addr`=`0x8000_0104`, `out_rdata`=`0xDEADBEEF`, `out_valid` at N+3.
- Signed byte load: addr `0x8000_0103`, `mem_rdata`=`0x80_12_34_56` → `out_rdata`=`0xFFFF_FF80`. Same access with `req_sign`=0 → `0x0000_0080`.
- Half store: addr `0x8000_0002`, wdata `0x1234_ABCD` → `mem_wmask`=`4'b1100`, `mem_wdata`=`0xABCD_ABCD`, `out_is_load`=0, `out_rdata`=0.
- Backpressure: `mem_req_ready` low for 5 cycles, response delayed 3 cycles, `out_ready` low for 4 cycles → all payloads remain stable and `req_ready` stays 0 until the output handshake completes.
- Error and misalignment:
  - `mem_rsp_err`=1 → `out_err`=1, `out_rdata`=0.
  - With `YSYX_25060170_LSU_MISALIGN_EN`, word load at `0x8000_0001` → `out_err`=1 at N+1, `mem_req_valid` never high.
- Reset mid-WAIT: assert `rst`=0 → `out_valid`=0 and `req_ready`=1 immediately. A late `mem_rsp_valid` after release produces no `out_valid`.
